b2p_stream_gen: RTL and testbench

- Binary-to-stochastic converter. Turns a BIN_LEN-bit unsigned value into a unary/stochastic bitstream whose count of ones over one window equals the value exactly.
- Window length is 2^BIN_LEN - 1 enabled cycles, the same window our stochastic-to-binary counter uses. Feeding this block's stream into that counter reproduces the loaded value.
- Sits at the input edge of the stochastic datapath.
- Has a one-entry load buffer so software/upstream can queue the next value while the current window streams.

---
 rtl/b2p_stream_gen.sv | 73 +++++++
 tb/tb_b2p_stream_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/b2p_stream_gen.sv
// Binary-to-stochastic converter: streams a BIN_LEN-bit value as a bitstream whose
// ones count over one (2^BIN_LEN - 1)-cycle window equals the value exactly.
module b2p_stream_gen #(
    parameter int                 BIN_LEN   = 8,
    parameter logic [BIN_LEN-1:0] LFSR_TAPS = 8'hB8,
    parameter logic [BIN_LEN-1:0] LFSR_SEED = 8'hFF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [BIN_LEN-1:0] in_val,
    input  logic               in_load,
    output logic               in_ready,
    output logic               out_bit,
    output logic               out_window_start,
    output logic [BIN_LEN-1:0] out_cur_val
);

    // Last slot of a window: WINDOW - 1 = 2^BIN_LEN - 2.
    localparam logic [BIN_LEN-1:0] LAST_CNT = {{(BIN_LEN-1){1'b1}}, 1'b0};

    logic [BIN_LEN-1:0] lfsr;
    logic [BIN_LEN-1:0] win_cnt;
    logic [BIN_LEN-1:0] active;
    logic [BIN_LEN-1:0] pend;
    logic               pend_valid;
    logic               at_boundary;

    function automatic logic [BIN_LEN-1:0] lfsr_step(input logic [BIN_LEN-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    assign in_ready    = !pend_valid;
    assign out_cur_val = active;
    assign at_boundary = (win_cnt == LAST_CNT);

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr             <= LFSR_SEED;
            win_cnt          <= '0;
            active           <= '0;
            pend             <= '0;
            pend_valid       <= 1'b0;
            out_bit          <= 1'b0;
            out_window_start <= 1'b0;
        end else begin
            // A full buffer cannot accept, so the swap below never collides with a load.
            if (in_load && !pend_valid) begin
                pend       <= in_val;
                pend_valid <= 1'b1;
            end

            if (enable) begin
                out_bit          <= (lfsr <= active);
                out_window_start <= (win_cnt == '0);
                if (at_boundary) begin
                    win_cnt <= '0;
                    lfsr    <= LFSR_SEED;
                    if (pend_valid) begin
                        active     <= pend;
                        pend_valid <= 1'b0;
                    end
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                    lfsr    <= lfsr_step(lfsr);
                end
            end else begin
                out_window_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_b2p_stream_gen.sv
// Randomized self-checking bench for b2p_stream_gen with a window-level reference
// model and a per-window ones counter acting as the stochastic-to-binary decoder.
module tb_b2p_stream_gen;

    localparam int WINDOW = 255;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] in_val = '0;
    logic       in_load = 1'b0;
    logic       in_ready;
    logic       out_bit;
    logic       out_window_start;
    logic [7:0] out_cur_val;

    int n_checks = 0;
    int n_errors = 0;

    b2p_stream_gen dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .in_val           (in_val),
        .in_load          (in_load),
        .in_ready         (in_ready),
        .out_bit          (out_bit),
        .out_window_start (out_window_start),
        .out_cur_val      (out_cur_val)
    );

    always #5 clock = ~clock;

    // Reference: the window visits the sequence of pseudo-random levels seq[0..254].
    int seq[WINDOW];
    int m_slot = 0, m_active = 0, m_pend = 0;
    bit m_pv = 0, m_bit = 0, m_ws = 0, m_adv = 0, m_rst = 0, m_valid = 0;

    int win_counts[$];
    bit have_win = 0;
    int wcnt = 0, wlen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_win(input string name, input int idx, input int exp);
        if (idx < win_counts.size()) chk(name, win_counts[idx], exp);
        else chk({name, "_missing"}, -1, exp);
    endtask

    always @(posedge clock) begin
        bit opv;
        opv   = m_pv;
        m_adv = enable && !reset;
        m_rst = reset;
        if (reset) begin
            m_slot = 0; m_active = 0; m_pend = 0; m_pv = 0;
            m_bit = 0; m_ws = 0; m_valid = 1;
        end else begin
            if (enable) begin
                m_bit = (seq[m_slot] <= m_active);
                m_ws  = (m_slot == 0);
                if (m_slot == WINDOW - 1) begin
                    m_slot = 0;
                    if (opv) begin
                        m_active = m_pend;
                        m_pv     = 0;
                    end
                end else begin
                    m_slot++;
                end
            end else begin
                m_ws = 0;
            end
            if (in_load && !opv) begin
                m_pend = in_val;
                m_pv   = 1;
            end
        end
    end

    // Compare process plus downstream window counter.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("out_bit", out_bit, m_bit);
            chk("out_window_start", out_window_start, m_ws);
            chk("out_cur_val", out_cur_val, m_active);
            chk("in_ready", in_ready, !m_pv);
            if (m_rst) begin
                have_win = 0;
            end else if (m_adv) begin
                if (out_window_start) begin
                    if (have_win) begin
                        chk("win_len", wlen, WINDOW);
                        win_counts.push_back(wcnt);
                    end
                    have_win = 1;
                    wcnt = int'(out_bit);
                    wlen = 1;
                end else if (have_win) begin
                    wcnt += int'(out_bit);
                    wlen++;
                end
            end
        end
    end

    task automatic tick(input bit r, input bit en, input bit ld, input int v);
        @(negedge clock);
        reset   = r;
        enable  = en;
        in_load = ld;
        in_val  = v[7:0];
    endtask

    task automatic do_reset();
        tick(1, 1, 0, 0);
        tick(1, 0, 0, 0);
        win_counts.delete();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(0, 1, 0, 0);
    endtask

    task automatic wait_ready(input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            if (in_ready) break;
            tick(0, 1, 0, 0);
        end
        if (i == 400) chk({name, "_ready_timeout"}, 0, 1);
    endtask

    initial begin
        int hits[256];
        int v;
        v = 8'hFF;
        for (int i = 0; i < WINDOW; i++) begin
            seq[i] = v;
            v = (v & 1) ? ((v >> 1) ^ 8'hB8) : (v >> 1);
        end
    end

    initial begin
        int hits[256];
        int bad;
        int i;
        #1;
        // Pin the reference sequence itself.
        chk("seq0", seq[0], 8'hFF);
        chk("seq1", seq[1], 8'hC7);
        chk("seq2", seq[2], 8'hDB);
        for (int k = 0; k < 256; k++) hits[k] = 0;
        for (int k = 0; k < WINDOW; k++) hits[seq[k]]++;
        bad = 0;
        for (int k = 1; k < 256; k++) if (hits[k] != 1) bad++;
        chk("seq_perm", bad + hits[0], 0);

        // 1: load 100 at cycle 0, three windows.
        do_reset();
        tick(0, 1, 1, 100);
        chk("rst_out_bit", out_bit, 0);
        chk("rst_ws", out_window_start, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_cur_val", out_cur_val, 0);
        run(3 * WINDOW + 5);
        chk_win("t1_w0", 0, 0);
        chk_win("t1_w1", 1, 100);
        chk_win("t1_w2", 2, 100);

        // 2: value 0 then 255.
        do_reset();
        tick(0, 1, 1, 0);
        tick(0, 1, 0, 0);
        wait_ready("t2");
        tick(0, 1, 1, 255);
        run(3 * WINDOW);
        chk_win("t2_w1", 1, 0);
        chk_win("t2_w2", 2, 255);

        // 3: second load while pending is dropped.
        do_reset();
        tick(0, 1, 1, 10);
        tick(0, 1, 1, 20);
        chk("t3_ready_low", in_ready, 0);
        wait_ready("t3");
        chk("t3_active10", out_cur_val, 10);
        tick(0, 1, 1, 30);
        run(2 * WINDOW + 10);
        chk_win("t3_w1", 1, 10);
        chk_win("t3_w2", 2, 30);

        // 4: random enable.
        do_reset();
        tick(0, 1, 1, 37);
        for (i = 0; i < 4000 && win_counts.size() < 3; i++)
            tick(0, 1'($urandom_range(0, 1)), 0, 0);
        chk_win("t4_w1", 1, 37);
        chk_win("t4_w2", 2, 37);

        // 5: reset mid-window with a pending value.
        do_reset();
        tick(0, 1, 1, 50);
        tick(0, 1, 0, 0);
        wait_ready("t5");
        tick(0, 1, 1, 60);
        for (i = 0; i < 300 && m_slot != 120; i++) tick(0, 1, 0, 0);
        chk("t5_reach120", int'(dut.win_cnt), 120);
        chk("t5_pend_valid", in_ready, 0);
        tick(1, 1, 0, 0);
        @(posedge clock); #1;
        chk("t5_out_bit", out_bit, 0);
        chk("t5_cur_val", out_cur_val, 0);
        chk("t5_ready", in_ready, 1);
        chk("t5_lfsr", int'(dut.lfsr), 8'hFF);
        tick(0, 1, 0, 0);
        @(posedge clock); #1;
        chk("t5_restart_ws", out_window_start, 1);

        // 6: round trip through the window counter.
        do_reset();
        tick(0, 1, 1, 1);
        tick(0, 1, 0, 0);
        wait_ready("t6a");
        tick(0, 1, 1, 128);
        tick(0, 1, 0, 0);
        wait_ready("t6b");
        tick(0, 1, 1, 254);
        run(3 * WINDOW + 10);
        chk_win("t6_w1", 1, 1);
        chk_win("t6_w2", 2, 128);
        chk_win("t6_w3", 3, 254);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
